// File: rtl/nibble_byte_packer_pkg.sv
// Shared types and widths for the nibble-to-byte packing stage.
package nibble_pkg;

  localparam int NIBBLE_W = 4;
  localparam int BYTE_W   = 8;

  // ST_LOW: waiting for a low nibble. ST_HIGH: low nibble held, waiting for the high one.
  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } state_e;

endpackage

// File: rtl/nibble_byte_packer_if.sv
// Bus bundle between the nibble source, the packer and the byte consumer.
interface nibble_byte_packer_if #(
  parameter int DEPTH = 4
);
  import nibble_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [NIBBLE_W-1:0] dataIn;
  logic                validIn;
  logic [BYTE_W-1:0]   byteOut;
  logic                byteValid;
  logic                byteReady;
  logic [CNT_W-1:0]    fifoCount;
  logic                halfPending;
  logic                overflow;
  logic                dropNibble;

  // The packer itself.
  modport slave (
    input  dataIn, validIn, byteReady,
    output byteOut, byteValid, fifoCount, halfPending, overflow, dropNibble
  );

  // Whatever drives nibbles in and consumes bytes out.
  modport master (
    output dataIn, validIn, byteReady,
    input  byteOut, byteValid, fifoCount, halfPending, overflow, dropNibble
  );
endinterface

// File: rtl/nibble_byte_packer_sync_fifo.sv
// Synchronous FIFO with a registered head output. A push into a full FIFO is
// accepted only when a pop happens on the same edge. The head register holds
// its last value once the FIFO drains.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             push_ok, pop_ok;

  // Next pointers, occupancy and head value.
  // NOTE: every signal gets a default first, so no path through this block can infer a latch.
  always_comb begin
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && ((count_q != CNT_W'(DEPTH)) || pop_ok);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    dout_d   = dout_q;
    if (count_d != '0) begin
      // The new head may be the entry being written on this very edge.
      dout_d = (push_ok && (wr_ptr_q == rd_ptr_d)) ? wdata : mem[rd_ptr_d];
    end
  end

  // Pointer, count and head registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  // Storage array write port.
  // NOTE: the array has no reset; entries are only read after being written, and the head register covers the reset value.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = dout_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/nibble_byte_packer.sv
// Pairs consecutive nibbles into bytes (first nibble low), queues them in a
// byte FIFO, flags bytes lost to a full FIFO, and discards a half byte that
// waited too long for its high nibble.
module nibble_byte_packer
  import nibble_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  nibble_byte_packer_if.slave   bus
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [NIBBLE_W-1:0] low_q, low_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                ovf_q, ovf_d;
  logic                drop_q, drop_d;
  logic                push, pop;
  logic [BYTE_W-1:0]   push_byte;
  logic                fifo_full, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;

  // Packing FSM, idle timeout and sticky overflow.
  always_comb begin
    state_d   = state_q;
    low_d     = low_q;
    idle_d    = idle_q;
    drop_d    = 1'b0;
    push      = 1'b0;
    push_byte = {bus.dataIn, low_q};
    pop       = !fifo_empty && bus.byteReady;
    unique case (state_q)
      ST_LOW: begin
        if (bus.validIn) begin
          low_d   = bus.dataIn;
          idle_d  = '0;
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (bus.validIn) begin
          push    = 1'b1;
          idle_d  = '0;
          state_d = ST_LOW;
        end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
          drop_d  = 1'b1;
          idle_d  = '0;
          state_d = ST_LOW;
        end else begin
          idle_d  = idle_q + IDLE_W'(1);
        end
      end
      default: state_d = ST_LOW;
    endcase
    ovf_d = ovf_q || (push && fifo_full && !pop);
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_LOW;
      low_q   <= '0;
      idle_q  <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      low_q   <= low_d;
      idle_q  <= idle_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (push_byte),
    .pop   (pop),
    .rdata (bus.byteOut),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.byteValid   = !fifo_empty;
  assign bus.fifoCount   = fifo_count;
  assign bus.halfPending = (state_q == ST_HIGH);
  assign bus.overflow    = ovf_q;
  assign bus.dropNibble  = drop_q;

endmodule

// File: tb/tb_nibble_byte_packer.sv
// Self-checking bench for nibble_byte_packer: a table of directed vectors,
// hand-written multi-cycle sequences, then random traffic against a queue model.
module tb_nibble_byte_packer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nibble_byte_packer_if #(.DEPTH(DEPTH)) bus ();

  nibble_byte_packer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a byte queue plus "is a low nibble waiting, and for how long".
  logic [7:0] m_q[$];
  bit         m_pend;
  logic [3:0] m_low;
  int         m_idle;
  bit         m_ovf;
  bit         m_drop;
  logic [7:0] m_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rn, input bit v, input logic [3:0] d, input bit r);
    m_drop = 1'b0;
    if (!rn) begin
      m_q.delete();
      m_pend = 1'b0;
      m_low  = '0;
      m_idle = 0;
      m_ovf  = 1'b0;
      m_last = 8'h00;
    end else begin
      if (m_q.size() > 0 && r) void'(m_q.pop_front());
      if (m_pend) begin
        if (v) begin
          if (m_q.size() < DEPTH) m_q.push_back({d, m_low});
          else                    m_ovf = 1'b1;
          m_pend = 1'b0;
        end else begin
          m_idle++;
          if (m_idle == TIMEOUT) begin
            m_pend = 1'b0;
            m_drop = 1'b1;
          end
        end
      end else if (v) begin
        m_pend = 1'b1;
        m_low  = d;
        m_idle = 0;
      end
      if (m_q.size() > 0) m_last = m_q[0];
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare #1 later.
  task automatic cycle(input bit rn, input bit v, input logic [3:0] d, input bit r);
    reset         = rn;
    bus.validIn   = v;
    bus.dataIn    = d;
    bus.byteReady = r;
    @(posedge clk);
    model_step(rn, v, d, r);
    #1;
    check("byteValid", 32'(bus.byteValid),   32'(m_q.size() > 0));
    check("byteOut",   32'(bus.byteOut),     32'(m_last));
    check("fifoCount", 32'(bus.fifoCount),   32'(m_q.size()));
    check("halfPend",  32'(bus.halfPending), 32'(m_pend));
    check("overflow",  32'(bus.overflow),    32'(m_ovf));
    check("dropNib",   32'(bus.dropNibble),  32'(m_drop));
  endtask

  typedef struct {
    bit         rn;
    bit         v;
    logic [3:0] d;
    bit         r;
    bit         e_valid;
    logic [7:0] e_out;
    int         e_cnt;
    bit         e_half;
    bit         e_ovf;
    bit         e_drop;
  } vec_t;

  vec_t tbl[$];
  logic [7:0] exp3 [4];
  logic [7:0] exp5 [4];

  initial begin
    reset = 1'b0; bus.validIn = 1'b0; bus.dataIn = '0; bus.byteReady = 1'b0;
    m_q.delete(); m_pend = 0; m_low = 0; m_idle = 0; m_ovf = 0; m_drop = 0; m_last = 0;

    // Directed table: reset, first byte E6, hold-on-empty, queued byte C5.
    for (int i = 0; i < 5; i++) tbl.push_back('{0, 0, 4'h0, 0, 0, 8'h00, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 4'h6, 1, 0, 8'h00, 0, 1, 0, 0});
    tbl.push_back('{1, 1, 4'hE, 1, 1, 8'hE6, 1, 0, 0, 0});
    tbl.push_back('{1, 0, 4'h0, 1, 0, 8'hE6, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 4'h5, 1, 0, 8'hE6, 0, 1, 0, 0});
    tbl.push_back('{1, 1, 4'hC, 0, 1, 8'hC5, 1, 0, 0, 0});
    tbl.push_back('{1, 0, 4'h0, 0, 1, 8'hC5, 1, 0, 0, 0});
    tbl.push_back('{1, 0, 4'h0, 1, 0, 8'hC5, 0, 0, 0, 0});
    foreach (tbl[i]) begin
      cycle(tbl[i].rn, tbl[i].v, tbl[i].d, tbl[i].r);
      check("tbl_valid", 32'(bus.byteValid),   32'(tbl[i].e_valid));
      check("tbl_out",   32'(bus.byteOut),     32'(tbl[i].e_out));
      check("tbl_count", 32'(bus.fifoCount),   32'(tbl[i].e_cnt));
      check("tbl_half",  32'(bus.halfPending), 32'(tbl[i].e_half));
      check("tbl_ovf",   32'(bus.overflow),    32'(tbl[i].e_ovf));
      check("tbl_drop",  32'(bus.dropNibble),  32'(tbl[i].e_drop));
    end

    // Fill with consumer stalled; fifth byte A9 is dropped, then drain in order.
    cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
    for (int n = 1; n <= 10; n++) begin
      cycle(1, 1, 4'(n), 0);
      if (n == 8) check("fill_ovf_before", 32'(bus.overflow), 32'd0);
    end
    check("fill_count", 32'(bus.fifoCount), 32'd4);
    check("fill_ovf",   32'(bus.overflow),  32'd1);
    exp3 = '{8'h21, 8'h43, 8'h65, 8'h87};
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 32'(bus.byteValid), 32'd1);
      check("drain_byte",  32'(bus.byteOut),   32'(exp3[i]));
      cycle(1, 0, 0, 1);
    end
    check("drain_empty", 32'(bus.byteValid), 32'd0);

    // Timeout: nibble 3 then 8 idle cycles discards it; next pair forms 21.
    cycle(1, 1, 4'h3, 1);
    for (int i = 1; i <= TIMEOUT; i++) begin
      cycle(1, 0, 0, 1);
      check("to_drop", 32'(bus.dropNibble), 32'(i == TIMEOUT));
    end
    check("to_half", 32'(bus.halfPending), 32'd0);
    cycle(1, 0, 0, 1);
    check("to_drop_once", 32'(bus.dropNibble), 32'd0);
    cycle(1, 1, 4'h1, 0);
    cycle(1, 1, 4'h2, 0);
    check("to_byte", 32'(bus.byteOut), 32'h21);
    // One idle cycle short of the timeout keeps the nibble.
    cycle(1, 1, 4'h4, 1);
    for (int i = 1; i < TIMEOUT; i++) cycle(1, 0, 0, 0);
    check("to_edge_half", 32'(bus.halfPending), 32'd1);
    cycle(1, 1, 4'h5, 1);
    cycle(1, 0, 0, 1);
    check("to_edge_byte", 32'(bus.byteOut), 32'h54);
    cycle(1, 0, 0, 1);

    // Full FIFO with a pop on the completing edge: both happen, no overflow.
    cycle(0, 0, 0, 0);
    for (int n = 0; n < 8; n++) cycle(1, 1, 4'(n), 0);
    cycle(1, 1, 4'h1, 0);
    cycle(1, 1, 4'h2, 1);
    check("fullpp_count", 32'(bus.fifoCount), 32'd4);
    check("fullpp_ovf",   32'(bus.overflow),  32'd0);
    exp5 = '{8'h32, 8'h54, 8'h76, 8'h21};
    for (int i = 0; i < 4; i++) begin
      check("fullpp_byte", 32'(bus.byteOut), 32'(exp5[i]));
      cycle(1, 0, 0, 1);
    end

    // Reset mid-operation with a half byte and two queued bytes.
    for (int n = 0; n < 5; n++) cycle(1, 1, 4'(n + 7), 0);
    check("mid_half",  32'(bus.halfPending), 32'd1);
    check("mid_count", 32'(bus.fifoCount),   32'd2);
    cycle(0, 1, 4'hF, 1);
    check("rst_valid", 32'(bus.byteValid),   32'd0);
    check("rst_out",   32'(bus.byteOut),     32'h00);
    check("rst_count", 32'(bus.fifoCount),   32'd0);
    check("rst_half",  32'(bus.halfPending), 32'd0);
    cycle(1, 1, 4'hA, 0);
    cycle(1, 1, 4'hB, 0);
    check("post_rst_byte", 32'(bus.byteOut), 32'hBA);

    // Random traffic in bursts of differing density, rare resets.
    begin
      int vprob = 50;
      for (int c = 0; c < 3000; c++) begin
        if (c % 64 == 0) vprob = (c / 64) % 3 == 0 ? 90 : ((c / 64) % 3 == 1 ? 50 : 8);
        cycle(($urandom_range(299) != 0),
              ($urandom_range(99) < vprob),
              4'($urandom_range(15)),
              ($urandom_range(99) < 45));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_byte_packer.md
Name: nibble_byte_packer

Overview:
- Downstream consumer of the 4-bit data bus stage; takes its dataOut/validOut nibble stream as input.
- Pairs consecutive nibbles into bytes (first nibble = low nibble) and queues them in a small FIFO.
- FIFO output uses a valid/ready handshake.
- Flags dropped bytes on overflow and discards a stale half-byte after an idle timeout.

Parameters:
DEPTH, 4, byte FIFO entries (power of 2, >=2)
TIMEOUT, 8, idle cycles in HIGH state before the pending low nibble is discarded (>=1)
CNT_W, $clog2(DEPTH+1), width of fifoCount

Ports:
clk  input  1  single system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk
dataIn  input  4  nibble from upstream bus stage
validIn  input  1  dataIn valid this cycle; no backpressure, always accepted
byteOut  output  8  FIFO head byte
byteValid  output  1  FIFO non-empty
byteReady  input  1  consumer accepts byteOut when byteValid && byteReady
fifoCount  output  CNT_W  bytes currently stored
halfPending  output  1  low nibble held, awaiting high nibble
overflow  output  1  sticky: a byte was dropped because FIFO full
dropNibble  output  1  one-cycle pulse: pending nibble discarded by timeout

Behaviour:
- Reset (reset==0 at clk edge): state=LOW, FIFO empty, byteOut=8'h00, byteValid=0, fifoCount=0, halfPending=0, overflow=0, dropNibble=0, idle counter=0. Applies mid-operation: pending nibble and all queued bytes are lost. Inputs are ignored while reset==0.
- FSM has two states:
  - LOW: validIn -> latch dataIn as low nibble, go HIGH, clear idle counter.
  - HIGH, validIn: form byte {dataIn, lowNibble}, push to FIFO, go LOW.
  - HIGH, !validIn: increment idle counter. When the counter reaches TIMEOUT-1 and validIn is still 0 in that cycle, go LOW and assert dropNibble for exactly the next cycle. The low nibble is discarded.
  - With TIMEOUT=8: low nibble at cycle t, no validIn in t+1..t+8 -> LOW after edge t+8, dropNibble high in cycle t+9 window.
- halfPending = (state==HIGH), registered.
- Push latency: byte written at the edge that samples the high nibble. byteValid/byteOut reflect it in the following cycle (1-cycle latency, empty FIFO).
- Pop occurs when byteValid && byteReady at the clk edge. The head advances; byteOut shows the next entry, or holds its last value if the FIFO becomes empty.
- Push into full FIFO:
  - With a pop in the same cycle: push accepted, count unchanged.
  - Without a pop: byte dropped, overflow set to 1 and held until reset, FSM still returns to LOW.
- Simultaneous push and pop on a non-full FIFO: count unchanged, order preserved.
- Pop on empty: impossible, since byteValid=0.
- Pointers wrap modulo DEPTH. fifoCount is in 0..DEPTH.
- byteOut is stable while byteValid && !byteReady. No combinational path from any input to any output.

Decomposition:
- Shared package nibble_pkg: state enum {ST_LOW, ST_HIGH}, NIBBLE_W=4, BYTE_W=8.
- One sub-module, sync_fifo: parameterised width/depth, push/pop/full/empty/count. Reusable by other bus stages.
- The packer FSM, idle counter and overflow logic live in the top.

Test Plan:
1. Reset held 0 for 5 cycles, then released -> byteValid=0, fifoCount=0, overflow=0, halfPending=0, byteOut=8'h00.
2. byteReady=1, nibbles 4'h6 then 4'hE on consecutive cycles -> byteValid for 1 cycle with byteOut=8'hE6. Then nibble 4'h5 -> halfPending=1.
3. byteReady=0, feed 10 nibbles 1..A -> bytes 21,43,65,87 queued, fifoCount=4. Fifth byte A9 dropped, overflow=1. Raise byteReady -> 21,43,65,87 out in order, then byteValid=0.
4. Nibble 4'h3, then validIn=0 for 8 cycles -> dropNibble pulses once, halfPending=0. Then nibbles 4'h1, 4'h2 -> byte 8'h21, not 8'h13.
5. Full FIFO, byteReady=1 in the same cycle as the completing nibble pair -> pop and push both occur, fifoCount stays 4, overflow stays 0.
6. Reset asserted with halfPending=1 and fifoCount=2 -> next cycle all outputs at reset values. Post-release nibbles 4'hA, 4'hB -> byteOut=8'hBA.
